// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipelined MIPS control unit.
//
// Decodes op/funct in DECODE, resolves beq/bne/j there, and carries the
// control bundle through ID/EX, MEM_LAT MEM stages and MEM/WB registers.
// The hazard unit injects bubbles into EX via stall_d_i / flush_e_i.
//
// Parameters:
//   MEM_LAT  - number of MEM pipeline stages (1..4)
//   EN_BNE   - 0 makes opcode 000101 (bne) illegal
//   EN_SHIFT - 0 makes R-type funct 000000 (sll) illegal
//
// Ports:
//   clk_i, rst_i              clock (rising edge), synchronous active-high reset
//   op_i6, funct_i6, eq_i     DECODE-stage instruction fields and rs==rt
//   stall_d_i, flush_e_i      hazard unit controls
//   pc_src_o, pc_j_o          taken branch / jump (DECODE)
//   flush_d_o, illegal_d_o    IF/ID clear, undecodable instruction (DECODE)
//   *_e_o                     EX-stage controls
//   *_m_o                     MEM-stage controls (mem_write from MEM1, rest from last MEM)
//   *_w_o                     WB-stage controls
module pipe_ctrl #(
  parameter int MEM_LAT  = 1,
  parameter int EN_BNE   = 1,
  parameter int EN_SHIFT = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i6,
  input  logic [5:0] funct_i6,
  input  logic       eq_i,
  input  logic       stall_d_i,
  input  logic       flush_e_i,
  output logic       pc_src_o,
  output logic       pc_j_o,
  output logic       flush_d_o,
  output logic       illegal_d_o,
  output logic       reg_write_e_o,
  output logic       mem_to_reg_e_o,
  output logic [2:0] alu_ctrl_e_o,
  output logic       alu_src_e_o,
  output logic       reg_dst_e_o,
  output logic       shift_e_o,
  output logic       reg_write_m_o,
  output logic       mem_to_reg_m_o,
  output logic       mem_write_m_o,
  output logic       reg_write_w_o,
  output logic       mem_to_reg_w_o
);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
      $error("pipe_ctrl: MEM_LAT must be in 1..4");
    end
  endgenerate

  // ---- DECODE (p0) ----
  logic       reg_write_p0, mem_to_reg_p0, mem_write_p0;
  logic [2:0] alu_ctrl_p0;
  logic       alu_src_p0, reg_dst_p0, shift_p0;
  logic       beq_p0, bne_p0, jmp_p0, illegal_p0;

  always_comb begin
    reg_write_p0  = 1'b0;
    mem_to_reg_p0 = 1'b0;
    mem_write_p0  = 1'b0;
    alu_ctrl_p0   = 3'b000;
    alu_src_p0    = 1'b0;
    reg_dst_p0    = 1'b0;
    shift_p0      = 1'b0;
    beq_p0        = 1'b0;
    bne_p0        = 1'b0;
    jmp_p0        = 1'b0;
    illegal_p0    = 1'b0;
    case (op_i6)
      6'b000000: begin
        reg_write_p0 = 1'b1;
        reg_dst_p0   = 1'b1;
        case (funct_i6)
          6'b100000: alu_ctrl_p0 = 3'b010;
          6'b100010: alu_ctrl_p0 = 3'b110;
          6'b100100: alu_ctrl_p0 = 3'b000;
          6'b100101: alu_ctrl_p0 = 3'b001;
          6'b101010: alu_ctrl_p0 = 3'b111;
          6'b000000: begin
            if (EN_SHIFT != 0) begin
              alu_ctrl_p0 = 3'b011;
              shift_p0    = 1'b1;
            end else begin
              illegal_p0 = 1'b1;
            end
          end
          default: illegal_p0 = 1'b1;
        endcase
      end
      6'b100011: begin
        reg_write_p0  = 1'b1;
        alu_src_p0    = 1'b1;
        mem_to_reg_p0 = 1'b1;
        alu_ctrl_p0   = 3'b010;
      end
      6'b101011: begin
        mem_write_p0 = 1'b1;
        alu_src_p0   = 1'b1;
        alu_ctrl_p0  = 3'b010;
      end
      6'b001000: begin
        reg_write_p0 = 1'b1;
        alu_src_p0   = 1'b1;
        alu_ctrl_p0  = 3'b010;
      end
      6'b000100: begin
        beq_p0      = 1'b1;
        alu_ctrl_p0 = 3'b110;
      end
      6'b000101: begin
        if (EN_BNE != 0) begin
          bne_p0      = 1'b1;
          alu_ctrl_p0 = 3'b110;
        end else begin
          illegal_p0 = 1'b1;
        end
      end
      6'b000010: jmp_p0 = 1'b1;
      default:   illegal_p0 = 1'b1;
    endcase
    // An undecodable instruction travels as a NOP; R-type defaults set above are undone here.
    if (illegal_p0) begin
      reg_write_p0 = 1'b0;
      reg_dst_p0   = 1'b0;
      alu_ctrl_p0  = 3'b000;
      shift_p0     = 1'b0;
    end
  end

  // A stalled branch/jump is held in DECODE and re-evaluated once the stall drops.
  assign pc_src_o    = !rst_i && !stall_d_i && ((beq_p0 && eq_i) || (bne_p0 && !eq_i));
  assign pc_j_o      = !rst_i && !stall_d_i && jmp_p0;
  assign flush_d_o   = pc_src_o || pc_j_o;
  assign illegal_d_o = !rst_i && illegal_p0;

  // ---- ID/EX (p1) ----
  logic       reg_write_p1, mem_to_reg_p1, mem_write_p1;
  logic [2:0] alu_ctrl_p1;
  logic       alu_src_p1, reg_dst_p1, shift_p1;
  logic       bubble_p1;

  assign bubble_p1 = rst_i || stall_d_i || flush_e_i;

  always_ff @(posedge clk_i) begin
    if (bubble_p1) begin
      reg_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      mem_write_p1  <= 1'b0;
      alu_ctrl_p1   <= 3'b000;
      alu_src_p1    <= 1'b0;
      reg_dst_p1    <= 1'b0;
      shift_p1      <= 1'b0;
    end else begin
      reg_write_p1  <= reg_write_p0;
      mem_to_reg_p1 <= mem_to_reg_p0;
      mem_write_p1  <= mem_write_p0;
      alu_ctrl_p1   <= alu_ctrl_p0;
      alu_src_p1    <= alu_src_p0;
      reg_dst_p1    <= reg_dst_p0;
      shift_p1      <= shift_p0;
    end
  end

  assign reg_write_e_o  = reg_write_p1;
  assign mem_to_reg_e_o = mem_to_reg_p1;
  assign alu_ctrl_e_o   = alu_ctrl_p1;
  assign alu_src_e_o    = alu_src_p1;
  assign reg_dst_e_o    = reg_dst_p1;
  assign shift_e_o      = shift_p1;

  // ---- MEM1..MEM_LAT (p2) ----
  // Bit 0 is MEM1; mem_write stops at MEM1.
  logic [MEM_LAT-1:0] reg_write_p2, mem_to_reg_p2;
  logic               mem_write_p2;

  generate
    if (MEM_LAT == 1) begin : g_mem_one
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          reg_write_p2  <= '0;
          mem_to_reg_p2 <= '0;
        end else begin
          reg_write_p2  <= reg_write_p1;
          mem_to_reg_p2 <= mem_to_reg_p1;
        end
      end
    end else begin : g_mem_multi
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          reg_write_p2  <= '0;
          mem_to_reg_p2 <= '0;
        end else begin
          reg_write_p2  <= {reg_write_p2[MEM_LAT-2:0], reg_write_p1};
          mem_to_reg_p2 <= {mem_to_reg_p2[MEM_LAT-2:0], mem_to_reg_p1};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) mem_write_p2 <= 1'b0;
    else       mem_write_p2 <= mem_write_p1;
  end

  assign reg_write_m_o  = reg_write_p2[MEM_LAT-1];
  assign mem_to_reg_m_o = mem_to_reg_p2[MEM_LAT-1];
  assign mem_write_m_o  = mem_write_p2;

  // ---- MEM/WB (p3) ----
  logic reg_write_p3, mem_to_reg_p3;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_write_p3  <= 1'b0;
      mem_to_reg_p3 <= 1'b0;
    end else begin
      reg_write_p3  <= reg_write_p2[MEM_LAT-1];
      mem_to_reg_p3 <= mem_to_reg_p2[MEM_LAT-1];
    end
  end

  assign reg_write_w_o  = reg_write_p3;
  assign mem_to_reg_w_o = mem_to_reg_p3;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl. Two instances share the stimulus:
//   inst 0: defaults (MEM_LAT=1, bne and sll enabled)
//   inst 1: MEM_LAT=3, bne and sll disabled
// Expected output fields are queued with the cycle they must appear in;
// the monitor checks them on the falling edge of that cycle.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       eq, stall, flush;

  logic       a_pcs, a_pcj, a_fld, a_ill, a_rwe, a_mre, a_src, a_dst, a_shf;
  logic       a_rwm, a_mrm, a_mwm, a_rww, a_mrw;
  logic [2:0] a_alu;
  logic       b_pcs, b_pcj, b_fld, b_ill, b_rwe, b_mre, b_src, b_dst, b_shf;
  logic       b_rwm, b_mrm, b_mwm, b_rww, b_mrw;
  logic [2:0] b_alu;

  always #5 clk = ~clk;

  pipe_ctrl dut_a (
    .clk_i(clk), .rst_i(rst), .op_i6(op), .funct_i6(funct), .eq_i(eq),
    .stall_d_i(stall), .flush_e_i(flush),
    .pc_src_o(a_pcs), .pc_j_o(a_pcj), .flush_d_o(a_fld), .illegal_d_o(a_ill),
    .reg_write_e_o(a_rwe), .mem_to_reg_e_o(a_mre), .alu_ctrl_e_o(a_alu),
    .alu_src_e_o(a_src), .reg_dst_e_o(a_dst), .shift_e_o(a_shf),
    .reg_write_m_o(a_rwm), .mem_to_reg_m_o(a_mrm), .mem_write_m_o(a_mwm),
    .reg_write_w_o(a_rww), .mem_to_reg_w_o(a_mrw)
  );

  pipe_ctrl #(.MEM_LAT(3), .EN_BNE(0), .EN_SHIFT(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .op_i6(op), .funct_i6(funct), .eq_i(eq),
    .stall_d_i(stall), .flush_e_i(flush),
    .pc_src_o(b_pcs), .pc_j_o(b_pcj), .flush_d_o(b_fld), .illegal_d_o(b_ill),
    .reg_write_e_o(b_rwe), .mem_to_reg_e_o(b_mre), .alu_ctrl_e_o(b_alu),
    .alu_src_e_o(b_src), .reg_dst_e_o(b_dst), .shift_e_o(b_shf),
    .reg_write_m_o(b_rwm), .mem_to_reg_m_o(b_mrm), .mem_write_m_o(b_mwm),
    .reg_write_w_o(b_rww), .mem_to_reg_w_o(b_mrw)
  );

  // Observation vector layout:
  // 16 pc_src 15 pc_j 14 flush_d 13 illegal | 12 rw_e 11 mr_e 10:8 alu 7 src 6 dst 5 shift
  // | 4 rw_m 3 mr_m 2 mw_m | 1 rw_w 0 mr_w
  logic [16:0] obs_a, obs_b;
  assign obs_a = {a_pcs, a_pcj, a_fld, a_ill, a_rwe, a_mre, a_alu, a_src, a_dst, a_shf,
                  a_rwm, a_mrm, a_mwm, a_rww, a_mrw};
  assign obs_b = {b_pcs, b_pcj, b_fld, b_ill, b_rwe, b_mre, b_alu, b_src, b_dst, b_shf,
                  b_rwm, b_mrm, b_mwm, b_rww, b_mrw};

  localparam logic [16:0] M_COMB = 17'h1E000;
  localparam logic [16:0] M_EX   = 17'h01FE0;
  localparam logic [16:0] M_MEM  = 17'h0001C;
  localparam logic [16:0] M_WB   = 17'h00003;
  localparam logic [16:0] M_ALL  = 17'h1FFFF;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SLL = 6'b000000, F_BAD = 6'b111111;

  function automatic logic [16:0] f_comb(logic pcs, logic pcj, logic fl, logic ill);
    return {pcs, pcj, fl, ill, 13'b0};
  endfunction
  function automatic logic [16:0] f_ex(logic rw, logic mr, logic [2:0] alu,
                                       logic src, logic dst, logic shf);
    return {4'b0, rw, mr, alu, src, dst, shf, 5'b0};
  endfunction
  function automatic logic [16:0] f_m(logic rw, logic mr, logic mw);
    return {12'b0, rw, mr, mw, 2'b0};
  endfunction
  function automatic logic [16:0] f_w(logic rw, logic mr);
    return {15'b0, rw, mr};
  endfunction

  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          q_at[$];
  int          q_inst[$];
  logic [16:0] q_mask[$];
  logic [16:0] q_val[$];
  string       q_name[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_at(input int at, input int inst, input logic [16:0] mask,
                        input logic [16:0] val, input string name);
    q_at.push_back(at);
    q_inst.push_back(inst);
    q_mask.push_back(mask);
    q_val.push_back(val);
    q_name.push_back(name);
  endtask

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    int          i;
    logic [16:0] got;
    i = 0;
    while (i < q_at.size()) begin
      if (q_at[i] == cyc) begin
        got = (q_inst[i] == 0) ? obs_a : obs_b;
        n_chk++;
        if ((got & q_mask[i]) !== (q_val[i] & q_mask[i])) begin
          n_fail++;
          $display("FAIL %s (inst %0d, cycle %0d): got %h required %h (mask %h)",
                   q_name[i], q_inst[i], cyc, got & q_mask[i], q_val[i] & q_mask[i], q_mask[i]);
        end
        q_at.delete(i);
        q_inst.delete(i);
        q_mask.delete(i);
        q_val.delete(i);
        q_name.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic step(input logic [5:0] o, input logic [5:0] f, input logic e,
                      input logic st, input logic fl, input logic rs);
    op = o; funct = f; eq = e; stall = st; flush = fl; rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(OP_BAD, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int c;
    op = OP_J; funct = 6'b0; eq = 1'b0; stall = 1'b0; flush = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset: combinational outputs forced low even with a jump presented.
    c = cyc;
    chk_at(c,     0, M_COMB, 17'h0, "rst_comb");
    chk_at(c + 1, 0, M_ALL,  17'h0, "rst_all_a");
    chk_at(c + 1, 1, M_ALL,  17'h0, "rst_all_b");
    step(OP_J, 6'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(OP_J, 6'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // lw through the pipe, both latencies.
    c = cyc;
    chk_at(c,     0, M_COMB, f_comb(0, 0, 0, 0), "lw_dec");
    chk_at(c + 1, 0, M_EX,   f_ex(1, 1, 3'b010, 1, 0, 0), "lw_ex");
    chk_at(c + 2, 0, M_MEM,  f_m(1, 1, 0), "lw_mem");
    chk_at(c + 3, 0, M_MEM | M_WB, f_w(1, 1), "lw_wb");
    chk_at(c + 3, 1, M_MEM,  f_m(0, 0, 0), "lw_mem_l3_early");
    chk_at(c + 4, 1, M_MEM,  f_m(1, 1, 0), "lw_mem_l3");
    chk_at(c + 5, 1, M_WB,   f_w(1, 1), "lw_wb_l3");
    step(OP_LW, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Branches and jump.
    c = cyc;
    chk_at(c,     0, M_COMB, f_comb(1, 0, 1, 0), "beq_eq1");
    chk_at(c + 1, 0, M_COMB | M_EX, f_ex(0, 0, 3'b110, 0, 0, 0), "bne_eq1");
    chk_at(c + 2, 0, M_COMB, f_comb(0, 0, 0, 0), "beq_eq0");
    chk_at(c + 3, 0, M_COMB, f_comb(1, 0, 1, 0), "bne_eq0");
    chk_at(c + 4, 0, M_COMB, f_comb(0, 1, 1, 0), "jump");
    chk_at(c + 1, 1, M_COMB, f_comb(0, 0, 0, 1), "bne_dis_eq1");
    chk_at(c + 2, 1, M_EX,   17'h0, "bne_dis_ex");
    chk_at(c + 3, 1, M_COMB, f_comb(0, 0, 0, 1), "bne_dis_eq0");
    chk_at(c + 4, 1, M_COMB, f_comb(0, 1, 1, 0), "jump_l3");
    step(OP_BEQ, 6'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(OP_BNE, 6'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(OP_BEQ, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_BNE, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_J,   6'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(5);

    // sw held by a two-cycle stall, then a stalled taken beq.
    c = cyc;
    chk_at(c + 1, 0, M_EX,   17'h0, "stall_bubble1");
    chk_at(c + 2, 0, M_EX | M_MEM, 17'h0, "stall_bubble2");
    chk_at(c + 3, 0, M_COMB | M_EX | M_MEM, f_ex(0, 0, 3'b010, 1, 0, 0), "sw_ex_beq_stalled");
    chk_at(c + 4, 0, M_COMB | M_MEM, f_comb(1, 0, 1, 0) | f_m(0, 0, 1), "sw_mem_beq_release");
    chk_at(c + 5, 0, M_MEM,  f_m(0, 0, 0), "sw_mem_once");
    chk_at(c + 4, 1, M_MEM,  f_m(0, 0, 1), "sw_mem_l3");
    step(OP_SW,  6'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(OP_SW,  6'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(OP_SW,  6'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_BEQ, 6'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(OP_BEQ, 6'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);

    // flush_e with stall, flush alone, then add; MEM_LAT=3 timing.
    c = cyc;
    chk_at(c + 1, 0, M_EX,   17'h0, "flush_stall");
    chk_at(c + 2, 0, M_EX,   17'h0, "flush_only");
    chk_at(c + 3, 0, M_EX | M_MEM, f_ex(1, 0, 3'b010, 0, 1, 0), "add_ex");
    chk_at(c + 4, 0, M_MEM,  f_m(1, 0, 0), "add_mem");
    chk_at(c + 5, 0, M_WB,   f_w(1, 0), "add_wb");
    chk_at(c + 4, 1, M_MEM,  f_m(0, 0, 0), "add_l3_mem1");
    chk_at(c + 5, 1, M_MEM,  f_m(0, 0, 0), "add_l3_early");
    chk_at(c + 6, 1, M_MEM,  f_m(1, 0, 0), "add_l3_mem");
    chk_at(c + 7, 1, M_WB,   f_w(1, 0), "add_l3_wb");
    step(OP_R, F_ADD, 1'b0, 1'b1, 1'b1, 1'b0);
    step(OP_R, F_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
    step(OP_R, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(7);

    // sll, illegal opcode, illegal funct.
    c = cyc;
    chk_at(c,     0, M_COMB, f_comb(0, 0, 0, 0), "sll_dec");
    chk_at(c + 1, 0, M_COMB | M_EX, f_comb(0, 0, 0, 1) | f_ex(1, 0, 3'b011, 0, 1, 1), "sll_ex_badop");
    chk_at(c + 2, 0, M_COMB | M_EX, f_comb(0, 0, 0, 1), "badop_ex_badfn");
    chk_at(c + 3, 0, M_EX | M_WB, f_w(1, 0), "sll_wb_badfn_ex");
    chk_at(c + 4, 0, M_MEM | M_WB, 17'h0, "badop_wb");
    chk_at(c + 5, 0, M_WB,   17'h0, "badfn_wb");
    chk_at(c,     1, M_COMB, f_comb(0, 0, 0, 1), "sll_dis");
    chk_at(c + 1, 1, M_EX,   17'h0, "sll_dis_ex");
    chk_at(c + 4, 1, M_MEM,  17'h0, "sll_dis_mem");
    chk_at(c + 5, 1, M_WB,   17'h0, "sll_dis_wb");
    step(OP_R,   F_SLL, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_BAD, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_R,   F_BAD, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);

    // Reset while lw is in MEM, then add retires normally.
    c = cyc;
    chk_at(c + 2, 0, M_COMB | M_MEM, f_m(1, 1, 0), "lw_in_mem_rst_comb");
    chk_at(c + 3, 0, M_ALL,  17'h0, "rst_mid_clear_a");
    chk_at(c + 3, 1, M_ALL,  17'h0, "rst_mid_clear_b");
    chk_at(c + 4, 0, M_EX | M_WB, f_ex(1, 0, 3'b010, 0, 1, 0), "post_rst_ex");
    chk_at(c + 5, 0, M_MEM,  f_m(1, 0, 0), "post_rst_mem");
    chk_at(c + 6, 0, M_WB,   f_w(1, 0), "post_rst_wb");
    chk_at(c + 4, 1, M_MEM,  17'h0, "rst_mid_l3_mem");
    chk_at(c + 7, 1, M_MEM,  f_m(1, 0, 0), "post_rst_l3_mem");
    chk_at(c + 8, 1, M_WB,   f_w(1, 0), "post_rst_l3_wb");
    step(OP_LW,  6'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_BAD, 6'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(OP_BAD, 6'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(OP_R,   F_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(8);

    n_chk++;
    if (q_at.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations unchecked, required 0", q_at.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
